// File: rtl/reg_file_pkg.sv
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared types and default geometry for the multi-port register file
//  Revision : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  // Default geometry, also used by the ALU wrapper.
  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_multi.sv
// ============================================================================
//  Module   : reg_file_multi
//  Purpose  : DEPTH x WIDTH register file, one write port, two registered read
//             ports, optional write bypass / zero register, clear sweep.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_multi
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  do_a,
  output logic [WIDTH-1:0]  do_b,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    do_a_q, do_a_d;
  logic [WIDTH-1:0]    do_b_q, do_b_d;
  logic                rd_valid_q, rd_valid_d;

  logic                w_idle;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_sweep_last;

  assign w_idle       = (state_q == IDLE);
  // A write to the hardwired zero entry is dropped before it can reach storage or bypass.
  assign w_wr_ok      = w_idle && wr_en && !(ZERO_REG && (wr_addr == '0));
  assign w_rd_ok      = w_idle && rd_en;
  assign w_sweep_last = (cnt_q == ADDR_W'(DEPTH - 1));

  // Value one read port captures this cycle: zero register first, then bypass, then storage.
  function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && (addr == '0)) begin
      return '0;
    end
    if (BYPASS && w_wr_ok && (addr == wr_addr)) begin
      return wr_data;
    end
    return mem_q[addr];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (w_sweep_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    do_a_d     = do_a_q;
    do_b_d     = do_b_q;
    rd_valid_d = 1'b0;
    if (w_rd_ok) begin
      do_a_d     = rd_sel(rd_addr_a);
      do_b_d     = rd_sel(rd_addr_b);
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      do_a_q     <= '0;
      do_b_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      do_a_q     <= do_a_d;
      do_b_q     <= do_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sweep and port writes are mutually exclusive: writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (w_wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign do_a     = do_a_q;
  assign do_b     = do_b_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule : reg_file_multi

`default_nettype wire

// File: tb/tb_reg_file_multi.sv
// ============================================================================
//  Module   : tb_reg_file_multi
//  Purpose  : Self-checking bench for reg_file_multi in three configurations
//             (bypass, no bypass, bypass + zero register) against a model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_multi;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          clr_req;

  logic [W-1:0]  dut_a    [NI];
  logic [W-1:0]  dut_b    [NI];
  logic          dut_v    [NI];
  logic          dut_busy [NI];

  always #5 clk = ~clk;

  reg_file_multi #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .do_a(dut_a[0]), .do_b(dut_b[0]), .rd_valid(dut_v[0]),
    .clr_req(clr_req), .busy(dut_busy[0])
  );

  reg_file_multi #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .do_a(dut_a[1]), .do_b(dut_b[1]), .rd_valid(dut_v[1]),
    .clr_req(clr_req), .busy(dut_busy[1])
  );

  reg_file_multi #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .do_a(dut_a[2]), .do_b(dut_b[2]), .rd_valid(dut_v[2]),
    .clr_req(clr_req), .busy(dut_busy[2])
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [NI][D];
  logic [W-1:0] m_a   [NI];
  logic [W-1:0] m_b   [NI];
  logic         m_v   [NI];
  logic         m_busy;
  int           m_idx;
  logic         m_init = 1'b0;

  function automatic bit cfg_byp(int k);
    return k != 1;
  endfunction

  function automatic bit cfg_zero(int k);
    return k == 2;
  endfunction

  function automatic logic [W-1:0] m_read(int k, logic [AW-1:0] addr);
    if (cfg_zero(k) && addr == 0) return '0;
    if (cfg_byp(k) && wr_en && addr == wr_addr && !(cfg_zero(k) && wr_addr == 0)) return wr_data;
    return m_mem[k][addr];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_idx  = 0;
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < D; i++) m_mem[k][i] = '0;
        m_a[k] = '0;
        m_b[k] = '0;
        m_v[k] = 1'b0;
      end
    end else if (m_busy) begin
      for (int k = 0; k < NI; k++) begin
        m_mem[k][m_idx] = '0;
        m_v[k] = 1'b0;
      end
      m_idx++;
      if (m_idx == D) m_busy = 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (rd_en) begin
          m_a[k] = m_read(k, rd_addr_a);
          m_b[k] = m_read(k, rd_addr_b);
        end
        m_v[k] = rd_en;
      end
      for (int k = 0; k < NI; k++) begin
        if (wr_en && !(cfg_zero(k) && wr_addr == 0)) m_mem[k][wr_addr] = wr_data;
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  // ---------------- compare process ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  string       q_name [$];
  logic [31:0] q_act  [$];
  logic [31:0] q_exp  [$];
  int          q_rd   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    model_edge();
    #1;
    if (m_init) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("u%0d do_a", k),     {24'd0, dut_a[k]},    {24'd0, m_a[k]});
        chk($sformatf("u%0d do_b", k),     {24'd0, dut_b[k]},    {24'd0, m_b[k]});
        chk($sformatf("u%0d rd_valid", k), {31'd0, dut_v[k]},    {31'd0, m_v[k]});
        chk($sformatf("u%0d busy", k),     {31'd0, dut_busy[k]}, {31'd0, m_busy});
      end
    end
    while (q_rd < q_name.size()) begin
      chk(q_name[q_rd], q_act[q_rd], q_exp[q_rd]);
      q_rd++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    q_name.push_back(nm);
    q_act.push_back(act);
    q_exp.push_back(exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  // Called right after the edge that started a sweep; counts busy cycles.
  task automatic sweep_count(output int cnt, input bit poke);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (dut_busy[0]) begin
        cnt++;
        lit($sformatf("sweep rd_valid i%0d", i), {31'd0, dut_v[0]}, 32'd0);
      end
      idle_in();
      if (poke && i == 1) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA;
        rd_en = 1'b1; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
      end
      if (poke && i == 2) clr_req = 1'b1;
      step();
    end
  endtask

  task automatic fill(logic [W-1:0] val);
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = val;
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_all_zero(string tag);
    for (int i = 0; i < D; i++) begin
      rd_en = 1'b1; rd_addr_a = AW'(i); rd_addr_b = AW'(D - 1 - i);
      step();
      lit($sformatf("%s do_a[%0d]", tag, i), {24'd0, dut_a[0]}, 32'h00);
      lit($sformatf("%s do_b[%0d]", tag, D - 1 - i), {24'd0, dut_b[0]}, 32'h00);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; idle_in();
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    step(); step();
    rst_n = 1'b1;
    lit("reset busy", {31'd0, dut_busy[0]}, 32'd0);
    lit("reset rd_valid", {31'd0, dut_v[0]}, 32'd0);

    // Basic read after reset
    rd_en = 1'b1; rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    step(); idle_in();
    lit("t1 do_a", {24'd0, dut_a[0]}, 32'h00);
    lit("t1 do_b", {24'd0, dut_b[0]}, 32'h00);
    lit("t1 rd_valid", {31'd0, dut_v[0]}, 32'd1);
    lit("t1 model rd_valid", {31'd0, m_v[0]}, 32'd1);

    // Write then read
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; step();
    wr_addr = 2'd1; wr_data = 8'h3C; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 2'd2; rd_addr_b = 2'd1; step();
    idle_in();
    lit("t2 do_a", {24'd0, dut_a[0]}, 32'hA5);
    lit("t2 do_b", {24'd0, dut_b[0]}, 32'h3C);
    lit("t2 model do_a", {24'd0, m_a[0]}, 32'hA5);
    lit("t2 model do_b", {24'd0, m_b[0]}, 32'h3C);

    // Same-cycle write and read of one address
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h11; step();
    wr_data = 8'h7E; rd_en = 1'b1; rd_addr_a = 2'd3; rd_addr_b = 2'd3; step();
    wr_en = 1'b0;
    lit("t3 byp do_a", {24'd0, dut_a[0]}, 32'h7E);
    lit("t3 byp do_b", {24'd0, dut_b[0]}, 32'h7E);
    lit("t3 nobyp do_a", {24'd0, dut_a[1]}, 32'h11);
    lit("t3 nobyp do_b", {24'd0, dut_b[1]}, 32'h11);
    lit("t3 model nobyp do_a", {24'd0, m_a[1]}, 32'h11);
    step(); idle_in();
    lit("t3 nobyp next do_a", {24'd0, dut_a[1]}, 32'h7E);

    // Zero register
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 2'd0; rd_addr_b = 2'd0; step();
    lit("t4 zero do_a", {24'd0, dut_a[2]}, 32'h00);
    lit("t4 zero do_b", {24'd0, dut_b[2]}, 32'h00);
    lit("t4 plain do_a", {24'd0, dut_a[0]}, 32'hFF);
    wr_en = 1'b1; wr_data = 8'hC3; step(); idle_in();
    lit("t4 zero bypass do_a", {24'd0, dut_a[2]}, 32'h00);
    lit("t4 zero bypass do_b", {24'd0, dut_b[2]}, 32'h00);
    lit("t4 plain bypass do_a", {24'd0, dut_a[0]}, 32'hC3);

    // Clear sweep with mid-sweep write/read and repeated clr_req
    fill(8'h55);
    clr_req = 1'b1; step();
    sweep_count(cnt, 1'b1);
    lit("t5 busy cycles", cnt, D);
    read_all_zero("t5");

    // Reset in the second sweep cycle, then a full sweep
    fill(8'h66);
    clr_req = 1'b1; step();
    idle_in(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    lit("t6 busy after reset", {31'd0, dut_busy[0]}, 32'd0);
    read_all_zero("t6");
    fill(8'h99);
    clr_req = 1'b1; step();
    sweep_count(cnt, 1'b0);
    lit("t6 busy cycles", cnt, D);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      clr_req   = ($urandom_range(0, 15) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      rd_en     = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, D - 1));
      wr_data   = W'($urandom);
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, D - 1));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, D - 1));
      step();
    end

    rst_n = 1'b1; idle_in();
    step(); step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_file_multi

`default_nettype wire

// File: doc/reg_file_multi.md
Name: reg_file_multi

Overview:
- Parametrised successor to the team's fixed 4x8 register bank: DEPTH entries of WIDTH bits, one write port and two registered read ports.
- Sits between the datapath sequencer and the ALU operand inputs.
- Adds the following, none of which the 4x8 bank has:
  - synchronous reset of all storage
  - simultaneous read and write in the same cycle, with optional write-to-read bypass
  - optional hardwired zero register
  - a multi-cycle clear sweep with busy flag and read-valid output

Parameters:
- WIDTH, 8: data width of each entry.
- DEPTH, 4: number of entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.
- BYPASS, 1: 1 = a same-cycle write to a read address is forwarded to that read output; 0 = the read returns the pre-write value.
- ZERO_REG, 0: 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read strobe for both read ports.
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_addr_b  in  ADDR_W  read address, port B.
- do_a  out  WIDTH  registered read data, port A.
- do_b  out  WIDTH  registered read data, port B.
- rd_valid  out  1  high for one cycle when do_a/do_b hold newly read data.
- clr_req  in  1  single-cycle pulse that starts a clear sweep.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset: clk is the only clock; rst_n is sampled on the rising edge of clk, is synchronous and active-low.
  - While rst_n = 0 at an edge: all entries, do_a, do_b, rd_valid, busy and the sweep counter go to 0; FSM goes to IDLE.
  - Reset overrides every other input, including mid-sweep.
- Write: when wr_en = 1 in IDLE, entry[wr_addr] <= wr_data at the edge. With ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read:
  - When rd_en = 1 in IDLE: do_a <= entry[rd_addr_a], do_b <= entry[rd_addr_b], rd_valid <= 1. Latency is one cycle.
  - When rd_en = 0: do_a/do_b hold their last value and rd_valid <= 0.
- Same-cycle read and write: wr_en and rd_en may both be 1.
  - With BYPASS = 1 and a read address equal to wr_addr (and the write not dropped by ZERO_REG), that port captures wr_data.
  - With BYPASS = 0, that port captures the old entry value.
  - Both ports may match the write address at once; each port is resolved independently.
- Zero register: with ZERO_REG = 1, any read of address 0 returns 0 regardless of bypass.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1: counter <= 0, busy <= 1 at that edge.
  - In CLEAR, each cycle: entry[counter] <= 0, counter <= counter + 1.
  - When counter = DEPTH-1, that entry is cleared, the FSM returns to IDLE and busy <= 0. The sweep takes exactly DEPTH cycles of busy = 1.
  - In CLEAR, wr_en and rd_en are ignored, rd_valid = 0, and do_a/do_b hold.
  - clr_req while already in CLEAR is ignored; the sweep does not restart.
- Simultaneous clr_req and wr_en/rd_en in IDLE: the write and read of that cycle complete, and the sweep starts at the same edge. That write is subsequently cleared by the sweep.
- Counter width is ADDR_W and it never wraps past DEPTH-1.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- No combinational path from inputs to outputs.

Decomposition:
- Package reg_file_pkg holds:
  - the FSM state type: 1-bit encoding, IDLE = 0, CLEAR = 1
  - the default WIDTH/DEPTH constants shared with the ALU wrapper.
- Single module; the read-port mux plus bypass compare is duplicated per port. No sub-module is required.
- A helper function rd_sel(addr) inside the module covers the bypass/zero logic.

Test Plan:
1. Reset and basic read: hold rst_n = 0 for 2 cycles, release; rd_en with rd_addr_a = 1, rd_addr_b = 3 -> one cycle later do_a = 0x00, do_b = 0x00, rd_valid = 1.
2. Write then read: write 0xA5 to addr 2 and 0x3C to addr 1; next cycle rd_addr_a = 2, rd_addr_b = 1 -> do_a = 0xA5, do_b = 0x3C one cycle later.
3. Bypass, with entry 3 = 0x11: same cycle wr_en to addr 3 with 0x7E, rd_en with both ports at addr 3.
   - BYPASS = 1 -> do_a = do_b = 0x7E.
   - BYPASS = 0 -> do_a = do_b = 0x11, and a read next cycle returns 0x7E.
4. Zero register: ZERO_REG = 1, write 0xFF to addr 0, then read addr 0 on both ports -> 0x00, including in the same-cycle bypass case.
5. Clear sweep: fill all entries with 0x55 and pulse clr_req.
   - busy is high for exactly DEPTH = 4 cycles.
   - A wr_en issued mid-sweep is ignored; rd_valid stays 0 during the sweep.
   - Afterwards all reads return 0x00.
   - A second clr_req mid-sweep does not extend busy.
6. Reset mid-sweep: assert rst_n = 0 during the second CLEAR cycle -> next edge busy = 0, FSM in IDLE, all entries 0; a new clr_req afterwards runs a full DEPTH-cycle sweep.
